uart_frame_loader: RTL

- Parametrised successor to the single-mode serial bootloader.
- Accepts framed, checksummed load records from the UART receiver and writes payload bytes into program RAM.
- Each record is answered with an ACK or NAK byte.
- Sits between the uart block (rx_data/rx_done, tx_data/tx_wr/tx_done) and the RAM write mux selected by boot enable.

---
 rtl/uart_frame_loader_pkg.sv | 8 +
 rtl/uart_frame_loader_csum.sv | 16 +
 rtl/uart_frame_loader.sv | 103 ++++++++++
 3 files changed

// File: rtl/uart_frame_loader_pkg.sv
// uart_frame_loader_pkg: shared state encoding and default framing constants for the frame loader.
package uart_frame_loader_pkg;
    typedef enum logic [2:0] {S_IDLE, S_AHI, S_ALO, S_LEN, S_DATA, S_CSUM, S_TX, S_TXW} state_t;
    localparam logic [7:0] SYNC_DEF = 8'hA5;
    localparam logic [7:0] ACK_DEF = 8'h06;
    localparam logic [7:0] NAK_DEF = 8'h15;
    localparam logic [8:0] LEN_ZERO_COUNT = 9'd256;
endpackage

// File: rtl/uart_frame_loader_csum.sv
// loader_csum: 8-bit mod-256 accumulator with clear/add and a compare against the received checksum.
module loader_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] din,
    input  logic [7:0] cmp,
    output logic       match
);
    logic [7:0] sum;
    always_ff @(posedge clk)
        if (rst || clr) sum <= '0;
        else if (add) sum <= sum + din;
    assign match = sum == cmp;
endmodule

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: loads framed, checksummed UART records into program RAM and answers ACK/NAK.
// Define LOADER_TIMEOUT_EN to NAK a frame after TIMEOUT idle cycles between bytes.
module uart_frame_loader
    import uart_frame_loader_pkg::*;
#(
    parameter int         ADDR_W    = 16,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEF,
    parameter logic [7:0] ACK_BYTE  = ACK_DEF,
    parameter logic [7:0] NAK_BYTE  = NAK_DEF,
    parameter int         TIMEOUT   = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [7:0]        tx_data,
    output logic              transmit,
    input  logic              tx_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_we,
    output logic              busy,
    output logic              frame_ok,
    output logic [7:0]        err_count
);
    state_t state, next;
    logic [7:0] addr_hi;
    logic [ADDR_W-1:0] ptr;
    logic [8:0] left;
    logic take, in_frame, match, expire, csum_ev;
    assign take = en && rx_done;
    assign in_frame = state inside {S_AHI, S_ALO, S_LEN, S_DATA, S_CSUM};
    assign csum_ev = take && state == S_CSUM;
    assign busy = state != S_IDLE;
    assign transmit = state == S_TX;
`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer;
    always_ff @(posedge clk)
        timer <= (rst || !in_frame || rx_done) ? '0 : timer + 1'b1;
    // a byte arriving on the expiry cycle wins over the timeout
    assign expire = en && in_frame && !rx_done && timer == TW'(TIMEOUT - 1);
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT == 0;
    assign expire = 1'b0;
`endif
    loader_csum u_csum (
        .clk   (clk),
        .rst   (rst),
        .clr   (take && state == S_IDLE && rx_data == SYNC_BYTE),
        .add   (take && state inside {S_AHI, S_ALO, S_LEN, S_DATA}),
        .din   (rx_data),
        .cmp   (rx_data),
        .match (match)
    );
    always_comb begin
        next = state;
        case (state)
            S_IDLE:  next = (take && rx_data == SYNC_BYTE) ? S_AHI : S_IDLE;
            S_AHI:   next = take ? S_ALO : S_AHI;
            S_ALO:   next = take ? S_LEN : S_ALO;
            S_LEN:   next = take ? S_DATA : S_LEN;
            S_DATA:  next = (take && left == 9'd1) ? S_CSUM : S_DATA;
            S_CSUM:  next = take ? S_TX : S_CSUM;
            S_TX:    next = S_TXW;
            S_TXW:   next = tx_done ? S_IDLE : S_TXW;
            default: next = S_IDLE;
        endcase
        if (expire) next = S_TX;
        if (!en) next = S_IDLE;
    end
    always_ff @(posedge clk)
        state <= rst ? S_IDLE : next;
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hi   <= '0;
            ptr       <= '0;
            left      <= '0;
            ram_addr  <= '0;
            ram_data  <= '0;
            ram_we    <= 1'b0;
            tx_data   <= '0;
            frame_ok  <= 1'b0;
            err_count <= '0;
        end else begin
            ram_we   <= take && state == S_DATA;
            frame_ok <= csum_ev && match;
            if (take && state == S_AHI) addr_hi <= rx_data;
            if (take && state == S_ALO) ptr <= ADDR_W'({addr_hi, rx_data});
            if (take && state == S_LEN) left <= (rx_data == 8'd0) ? LEN_ZERO_COUNT : {1'b0, rx_data};
            if (take && state == S_DATA) begin
                ram_addr <= ptr;
                ram_data <= rx_data;
                ptr      <= ptr + 1'b1;
                left     <= left - 1'b1;
            end
            if (csum_ev || expire) tx_data <= (csum_ev && match) ? ACK_BYTE : NAK_BYTE;
            if (((csum_ev && !match) || expire) && err_count != 8'hFF) err_count <= err_count + 1'b1;
        end
    end
endmodule
